// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder: oversamples SCK/CSB/SDI and decodes the command/address/data stream into register-file strobes.
// Optional HKSPI_BYTE_COUNT_EN: honor command bits[5:3] as a byte count, otherwise every command streams until CSB rises.
module hkspi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, csb_sync_q, sdi_sync_q;
    logic                   sck_prev_q, csb_prev_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   sck_s, csb_s, sdi_s, sck_rise, sck_fall, csb_fall;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] rx_byte;
    logic [7:0] tx_q, tx_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       sdo_q, sdo_d, wr_q, wr_d, rd_q, rd_d;
    logic       we_q, we_d, re_q, re_d, load_q, load_d, done_q, done_d, inc_q, inc_d;
    logic       last_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '0;
            csb_sync_q <= '1;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            csb_prev_q <= 1'b1;
            vld_q      <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], csb};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            sck_prev_q <= sck_s;
            csb_prev_q <= csb_s;
            vld_q      <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csb_s    = csb_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // The reset value of the CSB pipeline is not a real pad sample, so a CSB held low through reset is no new edge.
    assign csb_fall = ~csb_s & csb_prev_q & vld_q[SYNC_STAGES];
    assign rx_byte  = {rx_q, sdi_s};

`ifdef HKSPI_BYTE_COUNT_EN
    logic [2:0] n_q, byte_cnt_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_q        <= 3'd0;
            byte_cnt_q <= 3'd0;
        end else begin
            if (state_q == S_CMD && sck_rise && bit_cnt_q == 3'd7)
                n_q <= rx_byte[5:3];
            if (state_q == S_ADDR)
                byte_cnt_q <= 3'd0;
            else if (state_q == S_DATA && done_q)
                byte_cnt_q <= byte_cnt_q + 3'd1;
        end
    end
    assign last_byte = (n_q != 3'd0) && (byte_cnt_q + 3'd1 == n_q);
`else
    assign last_byte = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            sdo_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sdo_q     <= sdo_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            re_q      <= re_d;
            load_q    <= load_d;
            done_q    <= done_d;
            inc_q     <= inc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sdo_d     = sdo_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        load_d    = re_q;
        done_d    = 1'b0;
        inc_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sdo_d = 1'b0;
                if (csb_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            S_CMD: begin
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        wr_d    = rx_byte[7];
                        rd_d    = rx_byte[6];
                        state_d = (rx_byte[7:6] == 2'b00) ? S_HOLD : S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d  = rx_byte;
                        re_d    = rd_q;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (wr_q)
                            wdata_d = rx_byte;
                        done_d = 1'b1;
                    end
                end
                if (sck_fall && rd_q) begin
                    sdo_d = tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                end
                // Byte complete: write strobe first, then step the address and prefetch one cycle later.
                if (done_q) begin
                    we_d = wr_q;
                    if (last_byte)
                        state_d = S_HOLD;
                    else
                        inc_d = 1'b1;
                end
                if (inc_q) begin
                    addr_d = addr_q + 8'd1;
                    re_d   = rd_q;
                end
            end
            default: ;
        endcase

        if (load_q)
            tx_d = reg_rdata;

        if (csb_s) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            re_d    = 1'b0;
            done_d  = 1'b0;
            inc_d   = 1'b0;
            sdo_d   = 1'b0;
        end
    end

    assign sdo_oe    = (state_q == S_DATA) && rd_q;
    assign sdo       = sdo_q & sdo_oe;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = ~csb_s;

endmodule

// File: tb/tb_hkspi_responder.sv
// Directed bench for hkspi_responder: a table of SPI transactions with expected strobes and read data, plus abort/reset sequences.
module tb_hkspi_responder;
    localparam int SYNC = 2;
    localparam int HALF = 8;
`ifdef HKSPI_BYTE_COUNT_EN
    localparam logic [1:0] NWR3 = 2'd1;
`else
    localparam logic [1:0] NWR3 = 2'd2;
`endif

    logic       clock = 1'b0, reset = 1'b1, sck = 1'b0, csb = 1'b1, sdi = 1'b0;
    logic       sdo, sdo_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] mem [0:255];

    int checks = 0, errors = 0, cyc = 0, rise_cyc = 0, oe_bad = 0;
    bit oe_allowed = 0, oe_seen = 0;
    logic [7:0] we_aq[$], we_dq[$], re_aq[$];
    int we_lq[$];

    hkspi_responder #(.SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .sck(sck), .csb(csb), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Register bank model: read data registered on the read strobe.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (reg_we) begin
                we_aq.push_back(reg_addr);
                we_dq.push_back(reg_wdata);
                we_lq.push_back(cyc - rise_cyc);
            end
            if (reg_re) re_aq.push_back(reg_addr);
            if (sdo_oe) oe_seen = 1;
            if (sdo_oe && !oe_allowed) oe_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        we_aq.delete(); we_dq.delete(); we_lq.delete(); re_aq.delete();
        oe_bad = 0; oe_seen = 0; oe_allowed = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bits(input logic [7:0] v, input int nbits, input bit arm, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = v[i];
            wait_clk(HALF);
            sck = 1'b1;
            rise_cyc = cyc;
            rx[i] = sdo;
            if (i == 0 && arm) oe_allowed = 1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input int nd,
                        input logic [2:0][7:0] d, output logic [2:0][7:0] rx);
        logic [7:0] r;
        clear_log();
        rx = '0;
        csb = 1'b0;
        wait_clk(HALF);
        spi_bits(cmd, 8, 1'b0, r);
        spi_bits(addr, 8, cmd[6], r);
        for (int i = 0; i < nd; i++) begin
            spi_bits(d[i], 8, 1'b0, r);
            rx[i] = r;
        end
        wait_clk(HALF);
        csb = 1'b1;
        wait_clk(6);
        oe_allowed = 0;
        wait_clk(HALF);
    endtask

    typedef struct packed {
        logic [7:0]      cmd;
        logic [7:0]      addr;
        logic [1:0]      nd;
        logic [2:0][7:0] d;
        logic [1:0]      nwr;
        logic [1:0][7:0] wa;
        logic [1:0][7:0] wd;
        logic [2:0]      nre;
        logic [3:0][7:0] ra;
        logic [2:0][7:0] rx;
    } vec_t;

    vec_t vt [7];
    logic [2:0][7:0] got_rx;
    logic [7:0] r8;

    initial begin
        // cmd, addr, nd, data, nwr, waddr, wdata, nre, raddr, read bytes (element 0 in the low byte)
        vt[0] = {8'h40, 8'h03, 2'd1, 24'h000000, 2'd0, 16'h0000, 16'h0000, 3'd2, 32'h0000_0403, 24'h000011};
        vt[1] = {8'h40, 8'h00, 2'd3, 24'h000000, 2'd0, 16'h0000, 16'h0000, 3'd4, 32'h0302_0100, 24'h560400};
        vt[2] = {8'h80, 8'h0B, 2'd1, 24'h000001, 2'd1, 16'h000B, 16'h0001, 3'd0, 32'h0000_0000, 24'h000000};
        vt[3] = {8'h88, 8'h10, 2'd2, 24'h0055AA, NWR3, 16'h1110, 16'h55AA, 3'd0, 32'h0000_0000, 24'h000000};
        vt[4] = {8'h80, 8'hFF, 2'd2, 24'h003412, 2'd2, 16'h00FF, 16'h3412, 3'd0, 32'h0000_0000, 24'h000000};
        vt[5] = {8'hC0, 8'h20, 2'd2, 24'h00779A, 2'd2, 16'h2120, 16'h779A, 3'd3, 32'h0022_2120, 24'h003C5A};
        vt[6] = {8'h00, 8'h05, 2'd1, 24'h000012, 2'd0, 16'h0000, 16'h0000, 3'd0, 32'h0000_0000, 24'h000000};

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[8'h03] = 8'h11; mem[8'h00] = 8'h00; mem[8'h01] = 8'h04; mem[8'h02] = 8'h56;
        mem[8'h20] = 8'h5A; mem[8'h21] = 8'h3C;

        wait_clk(3);
        chk("reset addr", int'(reg_addr), 0);
        chk("reset wdata", int'(reg_wdata), 0);
        chk("reset sdo/oe/we/re/busy", int'({sdo, sdo_oe, reg_we, reg_re, busy}), 0);
        reset = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 7; v++) begin
            xfer(vt[v].cmd, vt[v].addr, int'(vt[v].nd), vt[v].d, got_rx);
            $display("vec %0d cmd 0x%02h addr 0x%02h: %0d writes, %0d reads", v, vt[v].cmd, vt[v].addr, we_aq.size(), re_aq.size());
            chk($sformatf("v%0d we count", v), we_aq.size(), int'(vt[v].nwr));
            for (int i = 0; i < we_aq.size() && i < int'(vt[v].nwr); i++) begin
                chk($sformatf("v%0d we%0d addr", v, i), int'(we_aq[i]), int'(vt[v].wa[i]));
                chk($sformatf("v%0d we%0d data", v, i), int'(we_dq[i]), int'(vt[v].wd[i]));
                chk($sformatf("v%0d we%0d latency", v, i), we_lq[i], SYNC + 2);
            end
            chk($sformatf("v%0d re count", v), re_aq.size(), int'(vt[v].nre));
            for (int i = 0; i < re_aq.size() && i < int'(vt[v].nre); i++)
                chk($sformatf("v%0d re%0d addr", v, i), int'(re_aq[i]), int'(vt[v].ra[i]));
            if (vt[v].cmd[6])
                for (int i = 0; i < int'(vt[v].nd); i++)
                    chk($sformatf("v%0d sdo byte%0d", v, i), int'(got_rx[i]), int'(vt[v].rx[i]));
            chk($sformatf("v%0d sdo_oe outside data", v), oe_bad, 0);
            chk($sformatf("v%0d sdo_oe seen", v), int'(oe_seen), int'(vt[v].cmd[6]));
            chk($sformatf("v%0d idle outputs", v), int'({busy, sdo_oe, reg_we, reg_re}), 0);
        end

        // CSB raised after 5 bits of a data byte: partial byte dropped.
        clear_log();
        csb = 1'b0; wait_clk(HALF);
        spi_bits(8'h80, 8, 1'b0, r8); spi_bits(8'h30, 8, 1'b0, r8); spi_bits(8'hA5, 5, 1'b0, r8);
        wait_clk(HALF); csb = 1'b1; wait_clk(12);
        $display("seq abort: %0d writes", we_aq.size());
        chk("abort we count", we_aq.size(), 0);
        chk("abort addr", int'(reg_addr), 8'h30);

        // CSB rises together with the 8th SCK rising edge: no strobe.
        clear_log();
        csb = 1'b0; wait_clk(HALF);
        spi_bits(8'h80, 8, 1'b0, r8); spi_bits(8'h50, 8, 1'b0, r8); spi_bits(8'hC3, 7, 1'b0, r8);
        sdi = 1'b1; wait_clk(HALF);
        sck = 1'b1; csb = 1'b1; wait_clk(HALF); sck = 1'b0; wait_clk(12);
        $display("seq csb-with-last-edge: %0d writes", we_aq.size());
        chk("csb wins we count", we_aq.size(), 0);

        // Reset mid-command with CSB held low; nothing decodes until a fresh CSB fall.
        clear_log();
        csb = 1'b0; wait_clk(HALF);
        spi_bits(8'h80, 4, 1'b0, r8);
        wait_clk(3); #2; reset = 1'b1; #1;
        chk("midreset addr", int'(reg_addr), 0);
        chk("midreset wdata", int'(reg_wdata), 0);
        chk("midreset sdo/oe/we/re/busy", int'({sdo, sdo_oe, reg_we, reg_re, busy}), 0);
        wait_clk(1); reset = 1'b0;
        spi_bits(8'h80, 8, 1'b0, r8); spi_bits(8'h60, 8, 1'b0, r8); spi_bits(8'h99, 8, 1'b0, r8);
        chk("post-reset busy", int'(busy), 1);
        chk("post-reset strobes", we_aq.size() + re_aq.size(), 0);
        wait_clk(HALF); csb = 1'b1; wait_clk(12);
        $display("seq mid-reset: %0d writes %0d reads", we_aq.size(), re_aq.size());

        xfer(8'h80, 8'h44, 1, 24'h000066, got_rx);
        $display("seq recover: %0d writes", we_aq.size());
        chk("recover we count", we_aq.size(), 1);
        if (we_aq.size() > 0) begin
            chk("recover we addr", int'(we_aq[0]), 8'h44);
            chk("recover we data", int'(we_dq[0]), 8'h66);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
